// File: rtl/ls_pkg.sv
// Shared types for the load/store store buffer: entry layout, drain FSM states and default depth.
package ls_pkg;

  localparam int unsigned SB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [29:0] addr_w;
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_entry_t;

  typedef enum logic {
    StIdle,
    StBusy
  } drain_state_e;

endpackage

// File: rtl/sb_match.sv
// Youngest-match search over the store buffer entries for a load probe word address.
module sb_match
  import ls_pkg::*;
#(
  parameter int unsigned Depth = SB_DEPTH_DEFAULT,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  sb_entry_t [Depth-1:0] entries_i,
  input  logic [Depth-1:0]      valid_i,
  input  logic [PtrW-1:0]       head_i,
  input  logic [29:0]           addr_i,
  output logic [PtrW-1:0]       hit_idx_o,
  output logic                  match_o
);

  logic [PtrW-1:0] idx;

  // Walk from oldest (head) to youngest so the last hit found is the youngest.
  always_comb begin
    match_o   = 1'b0;
    hit_idx_o = '0;
    idx       = head_i;
    for (int unsigned k = 0; k < Depth; k++) begin
      idx = head_i + PtrW'(k);
      if (valid_i[idx] && (entries_i[idx].addr_w == addr_i)) begin
        match_o   = 1'b1;
        hit_idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer: queues stores, drains them to memory in order, and forwards to loads.
module store_buffer
  import ls_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            st_valid_i,
  output logic            st_ready_o,
  input  logic [31:0]     st_addr_i,
  input  logic [31:0]     st_data_i,
  input  logic [3:0]      st_mask_i,
  input  logic            ld_valid_i,
  input  logic [31:0]     ld_addr_i,
  output logic            fwd_hit_o,
  output logic [31:0]     fwd_data_o,
  output logic            ld_stall_o,
  output logic            mem_req_o,
  output logic [31:0]     mem_addr_o,
  output logic [31:0]     mem_wdata_o,
  output logic [3:0]      mem_wmask_o,
  input  logic            mem_ack_i,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  sb_entry_t [DEPTH-1:0] entries_q;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;
  drain_state_e          state_q, state_d;

  logic            push, pop;
  logic            match;
  logic [PtrW-1:0] hit_idx;
  logic [31:0]     win_data;
  logic [3:0]      win_mask;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{st_addr_i[1:0], ld_addr_i[1:0]};

  // Full is judged on the registered count only; a pop never frees a slot in the same cycle.
  assign st_ready_o = (count_q != CntW'(DEPTH));
  assign push       = st_valid_i && st_ready_o;
  assign mem_req_o  = (state_q == StBusy);
  assign pop        = mem_req_o && mem_ack_i;

  assign mem_addr_o  = {entries_q[head_q].addr_w, 2'b00};
  assign mem_wdata_o = entries_q[head_q].data;
  assign mem_wmask_o = entries_q[head_q].mask;
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PtrW'(1);
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (count_q != '0) state_d = StBusy;
      StBusy: if (mem_ack_i && (count_q == CntW'(1)) && !push) state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= StIdle;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Payload storage needs no reset: every read is qualified by a valid bit or the FSM.
  always_ff @(posedge clock_i) begin
    if (push) begin
      entries_q[tail_q] <= '{addr_w: st_addr_i[31:2], data: st_data_i, mask: st_mask_i};
    end
  end

  sb_match #(
    .Depth(DEPTH)
  ) u_match (
    .entries_i(entries_q),
    .valid_i  (valid_q),
    .head_i   (head_q),
    .addr_i   (ld_addr_i[31:2]),
    .hit_idx_o(hit_idx),
    .match_o  (match)
  );

  assign win_data   = entries_q[hit_idx].data;
  assign win_mask   = entries_q[hit_idx].mask;
  assign fwd_hit_o  = ld_valid_i && match && (win_mask == 4'hF);
  assign ld_stall_o = ld_valid_i && match && (win_mask != 4'hF);
  assign fwd_data_o = fwd_hit_o ? win_data : 32'h0;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: scoreboarded memory writes plus forwarding/stall probes.
module tb_store_buffer;
  import ls_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;

  logic            clock = 1'b0;
  logic            reset, st_valid, st_ready, ld_valid, fwd_hit, ld_stall;
  logic            mem_req, mem_ack, empty;
  logic [31:0]     st_addr, st_data, ld_addr, fwd_data, mem_addr, mem_wdata;
  logic [3:0]      st_mask, mem_wmask;
  logic [CntW-1:0] count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_t;

  wr_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 clock = ~clock;

  store_buffer #(
    .DEPTH(DEPTH)
  ) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .st_valid_i (st_valid),
    .st_ready_o (st_ready),
    .st_addr_i  (st_addr),
    .st_data_i  (st_data),
    .st_mask_i  (st_mask),
    .ld_valid_i (ld_valid),
    .ld_addr_i  (ld_addr),
    .fwd_hit_o  (fwd_hit),
    .fwd_data_o (fwd_data),
    .ld_stall_o (ld_stall),
    .mem_req_o  (mem_req),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_wmask_o(mem_wmask),
    .mem_ack_i  (mem_ack),
    .empty_o    (empty),
    .count_o    (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; everything is sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_t e;
    e.addr = a & 32'hFFFF_FFFC;
    e.data = d;
    e.mask = m;
    sb_q.push_back(e);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic acc = 1'b0;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mask  = m;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clock);
      acc = st_ready;
      if (acc) push_exp(a, d, m);
      tick();
    end
    st_valid = 1'b0;
    chk("store_accepted", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    logic done = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (count == '0) done = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("drain_done", {31'b0, done}, 32'd1);
  endtask

  // Scoreboard: every accepted write is checked against the oldest expected store.
  always @(negedge clock) begin
    wr_t e;
    if (!reset && mem_req && mem_ack) begin
      if (sb_q.size() == 0) begin
        chk("write_expected_count", 32'd1, 32'd0 + sb_q.size());
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
        chk("wr_mask", {28'b0, mem_wmask}, {28'b0, e.mask});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    ld_valid = 1'b1;
    ld_addr = 32'h1000;
    @(negedge clock);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_fwd_hit", {31'b0, fwd_hit}, 32'd0);
    chk("rst_ld_stall", {31'b0, ld_stall}, 32'd0);
    tick();

    // Single full-word store, held request, forwarding, then drain
    store(32'h1000, 32'hDEAD_BEEF, 4'hF);
    @(negedge clock);
    chk("s1_count", {29'b0, count}, 32'd1);
    chk("s1_req_not_yet", {31'b0, mem_req}, 32'd0);
    chk("s1_fwd_hit", {31'b0, fwd_hit}, 32'd1);
    chk("s1_fwd_data", fwd_data, 32'hDEAD_BEEF);
    tick();
    @(negedge clock);
    chk("s1_req", {31'b0, mem_req}, 32'd1);
    chk("s1_addr", mem_addr, 32'h1000);
    tick();
    @(negedge clock);
    chk("s1_req_held", {31'b0, mem_req}, 32'd1);
    chk("s1_addr_held", mem_addr, 32'h1000);
    chk("s1_wdata_held", mem_wdata, 32'hDEAD_BEEF);
    tick();
    drain();
    @(negedge clock);
    chk("s1_post_fwd_hit", {31'b0, fwd_hit}, 32'd0);
    chk("s1_post_req", {31'b0, mem_req}, 32'd0);
    chk("s1_post_empty", {31'b0, empty}, 32'd1);
    tick();

    // Two stores to one word: youngest wins, survives pop of the older one
    store(32'h2000, 32'h1111_1111, 4'hF);
    store(32'h2000, 32'h2222_2222, 4'hF);
    ld_addr = 32'h2002;
    @(negedge clock);
    chk("s2_fwd_hit", {31'b0, fwd_hit}, 32'd1);
    chk("s2_fwd_data", fwd_data, 32'h2222_2222);
    chk("s2_count", {29'b0, count}, 32'd2);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    @(negedge clock);
    chk("s2_count_after_pop", {29'b0, count}, 32'd1);
    chk("s2_fwd_data_after_pop", fwd_data, 32'h2222_2222);
    tick();
    drain();

    // Partial mask store stalls the load until it drains
    store(32'h3000, 32'h0000_ABCD, 4'b0011);
    ld_addr = 32'h3000;
    @(negedge clock);
    chk("s3_stall", {31'b0, ld_stall}, 32'd1);
    chk("s3_fwd_hit", {31'b0, fwd_hit}, 32'd0);
    chk("s3_fwd_data_zero", fwd_data, 32'd0);
    tick();
    drain();
    @(negedge clock);
    chk("s3_stall_cleared", {31'b0, ld_stall}, 32'd0);
    tick();

    // Fill, then pop with a store waiting; tail wraps to slot 0
    for (int i = 0; i < 4; i++) store(32'h4000 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 4'hF);
    ld_addr = 32'h400C;
    @(negedge clock);
    chk("s4_full_ready", {31'b0, st_ready}, 32'd0);
    chk("s4_full_count", {29'b0, count}, 32'd4);
    chk("s4_fwd_data", fwd_data, 32'hA0A0_0003);
    tick();
    st_valid = 1'b1; st_addr = 32'h4010; st_data = 32'hA0A0_0004; st_mask = 4'hF;
    mem_ack = 1'b1;
    @(negedge clock);
    chk("s4_ack_ready", {31'b0, st_ready}, 32'd0);
    chk("s4_ack_count", {29'b0, count}, 32'd4);
    tick();
    @(negedge clock);
    chk("s4_after_pop_count", {29'b0, count}, 32'd3);
    chk("s4_after_pop_ready", {31'b0, st_ready}, 32'd1);
    push_exp(32'h4010, 32'hA0A0_0004, 4'hF);
    tick();
    st_valid = 1'b0;
    ld_addr = 32'h4010;
    @(negedge clock);
    chk("s4_simul_count", {29'b0, count}, 32'd3);
    chk("s4_wrapped_fwd", fwd_data, 32'hA0A0_0004);
    tick();
    drain();

    // Reset while busy discards everything; a late ack has no effect
    store(32'h5000, 32'h5555_0000, 4'hF);
    store(32'h5004, 32'h5555_0001, 4'hF);
    store(32'h5008, 32'h5555_0002, 4'hF);
    tick();
    @(negedge clock);
    chk("s5_busy_req", {31'b0, mem_req}, 32'd1);
    chk("s5_busy_count", {29'b0, count}, 32'd3);
    tick();
    reset = 1'b1;
    mem_ack = 1'b1;
    sb_q.delete();
    tick();
    reset = 1'b0;
    ld_addr = 32'h5000;
    @(negedge clock);
    chk("s5_req", {31'b0, mem_req}, 32'd0);
    chk("s5_count", {29'b0, count}, 32'd0);
    chk("s5_empty", {31'b0, empty}, 32'd1);
    chk("s5_fwd_hit", {31'b0, fwd_hit}, 32'd0);
    chk("s5_ld_stall", {31'b0, ld_stall}, 32'd0);
    tick();
    @(negedge clock);
    chk("s5_late_ack_req", {31'b0, mem_req}, 32'd0);
    chk("s5_late_ack_count", {29'b0, count}, 32'd0);
    tick();
    mem_ack = 1'b0;

    chk("sb_drained", 32'd0 + sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
